pdm_axis_packer: RTL

Packs the serial PDM bit stream from the microphone front end into 32-bit words and presents them on an AXI4-Stream master port for the AXI stream FIFO to the PS. It consumes the one-bit-per-valid-pulse `mic_data`/`mic_data_valid` output of the PDM capture stage. It also inserts `tlast` at fixed frame boundaries and reports words lost to backpressure.

---
 rtl/pdm_axis_packer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pdm_axis_packer.sv
// pdm_axis_packer
//   Packs the one-bit-per-strobe PDM stream into 32-bit words (LSB first) and
//   presents them on an AXI4-Stream master port through a one-word holding
//   register. tlast marks the last word of every WORDS_PER_FRAME-word frame.
//   Words completed while the holding register is stalled are dropped and
//   counted.
//
// Ports
//   clk             system clock (shared with the PDM capture stage)
//   rst             synchronous active-high reset
//   mic_data        PDM sample, only bit 0 is used
//   mic_data_valid  single-cycle strobe, one per PDM bit
//   enable          capture enable; low discards any partial word/frame
//   ovf_clr         pulse, clears overflow and drop_count
//   m_axis_*        AXI4-Stream master (tdata, tvalid, tready, tlast)
//   overflow        sticky, at least one word was dropped
//   drop_count      saturating count of dropped words
module pdm_axis_packer #(
    parameter int unsigned WORDS_PER_FRAME = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mic_data,
    input  logic        mic_data_valid,
    input  logic        enable,
    input  logic        ovf_clr,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam logic [15:0] LAST_WORD = 16'(WORDS_PER_FRAME - 1);

    logic [31:0] sr_q, sr_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        tvalid_q, tvalid_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic        accept;
    logic        word_done;
    logic        load;
    logic        drop;
    logic [31:0] full_word;

    always_comb begin
        accept    = mic_data_valid && enable;
        word_done = accept && (bit_cnt_q == 5'd31);
        load      = word_done && (!tvalid_q || m_axis_tready);
        drop      = word_done && tvalid_q && !m_axis_tready;
        // Bits 30:0 were all written earlier in this word; bit 31 arrives now.
        full_word = {mic_data[0], sr_q[30:0]};
    end

    always_comb begin
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        wcnt_d       = wcnt_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (!enable) begin
            sr_d      = '0;
            bit_cnt_d = '0;
            wcnt_d    = '0;
        end else if (accept) begin
            sr_d[bit_cnt_q] = mic_data[0];
            bit_cnt_d       = bit_cnt_q + 5'd1;
        end

        if (load) begin
            tdata_d  = full_word;
            tlast_d  = (wcnt_q == LAST_WORD);
            tvalid_d = 1'b1;
            wcnt_d   = (wcnt_q == LAST_WORD) ? 16'd0 : wcnt_q + 16'd1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        // A drop in the same cycle as ovf_clr wins and restarts the count at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (ovf_clr) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            wcnt_q       <= '0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            wcnt_q       <= wcnt_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;

endmodule
